// File: rtl/dct_pkg.sv
// Shared constants for the 2-D DCT pipeline.
// Vectors carry DCT_N lanes; lane k sits at [k*DATA_WIDTH +: DATA_WIDTH].
package dct_pkg;

    localparam int unsigned DCT_N     = 8;
    localparam int unsigned DCT_IDX_W = 3;

    function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned width);
        return k * width;
    endfunction

endpackage

// File: rtl/dct_tbuf_bank.sv
// One 8x8 register bank of the transpose buffer.
// Row-wise write port and a combinational column read port.
module dct_tbuf_bank
    import dct_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          clk_i,
    input  logic                          we_i,
    input  logic [DCT_IDX_W-1:0]          row_idx_i,
    input  logic [DATA_WIDTH*DCT_N-1:0]   row_i,
    input  logic [DCT_IDX_W-1:0]          col_idx_i,
    output logic [DATA_WIDTH*DCT_N-1:0]   col_o
);

    logic [DATA_WIDTH*DCT_N-1:0] row_q [DCT_N];

    for (genvar r = 0; r < DCT_N; r++) begin : g_row
        // Contents are intentionally not reset; validity is tracked by the controller.
        always_ff @(posedge clk_i) begin
            if (we_i && (row_idx_i == DCT_IDX_W'(r))) begin
                row_q[r] <= row_i;
            end
        end

        assign col_o[lane_lsb(r, DATA_WIDTH) +: DATA_WIDTH] =
            row_q[r][lane_lsb(32'(col_idx_i), DATA_WIDTH) +: DATA_WIDTH];
    end

endmodule

// File: rtl/dct_transpose_8x8.sv
// Ping-pong 8x8 transpose between the row and column 1-D DCT passes.
// Rows fill one bank while the other drains as columns.
module dct_transpose_8x8
    import dct_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH*DCT_N-1:0]   in_row,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH*DCT_N-1:0]   out_col,
    output logic [DCT_IDX_W-1:0]          out_col_idx,
    output logic                          out_last
);

    localparam int unsigned VEC_W = DATA_WIDTH * DCT_N;
    localparam logic [DCT_IDX_W-1:0] LAST_IDX = DCT_IDX_W'(DCT_N - 1);

    logic [1:0]           bank_full_q, bank_full_d;
    logic                 wr_sel_q, wr_sel_d;
    logic                 rd_sel_q, rd_sel_d;
    logic [DCT_IDX_W-1:0] wr_row_q, wr_row_d;
    logic [DCT_IDX_W-1:0] rd_col_q, rd_col_d;

    logic                 wr_fire, rd_fire;
    logic [1:0]           bank_we;
    logic [VEC_W-1:0]     bank_col [2];

    assign in_ready    = !bank_full_q[wr_sel_q];
    assign out_valid   = bank_full_q[rd_sel_q];
    assign wr_fire     = in_valid && in_ready;
    assign rd_fire     = out_valid && out_ready;
    assign out_col     = rd_sel_q ? bank_col[1] : bank_col[0];
    assign out_col_idx = rd_col_q;
    assign out_last    = out_valid && (rd_col_q == LAST_IDX);

    // A completing write and a completing read never hit the same bank, so both apply.
    always_comb begin
        bank_full_d = bank_full_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        wr_row_d    = wr_row_q;
        rd_col_d    = rd_col_q;
        if (wr_fire) begin
            wr_row_d = wr_row_q + DCT_IDX_W'(1);
            if (wr_row_q == LAST_IDX) begin
                bank_full_d[wr_sel_q] = 1'b1;
                wr_sel_d              = !wr_sel_q;
            end
        end
        if (rd_fire) begin
            rd_col_d = rd_col_q + DCT_IDX_W'(1);
            if (rd_col_q == LAST_IDX) begin
                bank_full_d[rd_sel_q] = 1'b0;
                rd_sel_d              = !rd_sel_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bank_full_q <= 2'b00;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            wr_row_q    <= '0;
            rd_col_q    <= '0;
        end else begin
            bank_full_q <= bank_full_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            wr_row_q    <= wr_row_d;
            rd_col_q    <= rd_col_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b] = wr_fire && (wr_sel_q == 1'(b));

        dct_tbuf_bank #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk_i     (clk),
            .we_i      (bank_we[b]),
            .row_idx_i (wr_row_q),
            .row_i     (in_row),
            .col_idx_i (rd_col_q),
            .col_o     (bank_col[b])
        );
    end

endmodule
